// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: ALU width, multiplier state encoding, and
// the last shift-add iteration index.
package arith_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/ALU_4b.sv
// 4-bit adder used as the sole arithmetic resource of the multiplier.
// Carry is the fifth sum bit; overflow is the signed-overflow indication.
module ALU_4b
    import arith_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    logic [ALU_W:0] w_sum;

    assign w_sum    = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
    assign result   = w_sum[ALU_W-1:0];
    assign carry    = w_sum[ALU_W];
    assign overflow = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
    assign zero     = (result == '0);

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with valid/ready handshakes on
// both sides; one partial-product add per cycle through a single ALU_4b.
module mul4_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               zero,
    output state_t             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid outputs decode the state register only, never the
    // partner's input, and the producer may drop valid when not accepted.

    if (WIDTH != ALU_W) begin : g_bad_width
        $error("mul4_seq: WIDTH must equal ALU_W (4)");
    end

    state_t             r_state;
    logic [ALU_W-1:0]   r_mcand;
    logic [ALU_W-1:0]   r_acc_hi;
    logic [ALU_W-1:0]   r_acc_lo;
    logic [1:0]         r_cnt;

    logic               w_accept;
    logic [ALU_W-1:0]   w_alu_b;
    logic [ALU_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_alu_unused_ovf;
    logic               w_alu_unused_zero;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_alu_b  = r_acc_lo[0] ? r_mcand : '0;

    ALU_4b u_alu (
        .a        (r_acc_hi),
        .b        (w_alu_b),
        .cin      (1'b0),
        .result   (w_sum),
        .carry    (w_carry),
        .overflow (w_alu_unused_ovf),
        .zero     (w_alu_unused_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept)            r_state <= S_CALC;
                S_CALC:  if (r_cnt == ITER_LAST)  r_state <= S_DONE;
                S_DONE:  if (out_ready)           r_state <= S_IDLE;
                default:                          r_state <= S_IDLE;
            endcase
        end
    end

    // Multiplier bits shift out of acc_lo as product bits shift in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            {r_acc_hi, r_acc_lo} <= {w_carry, w_sum, r_acc_lo[ALU_W-1:1]};
            r_cnt                <= r_cnt + 2'd1;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign product   = out_valid ? {r_acc_hi, r_acc_lo} : '0;
    assign zero      = out_valid && ({r_acc_hi, r_acc_lo} == '0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mul4_seq.sv
// Bench for mul4_seq: directed vector table, backpressure and reset corner
// cases, back-to-back throughput and an exhaustive sweep against a*b.
module tb_mul4_seq;
    import arith_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       zero;
    state_t     dbg_state;

    mul4_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [8:0] exp_q[$];
    bit         mon_en   = 1'b0;
    bit         b2b_chk  = 1'b0;
    int         cyc      = 0;
    int         last_acc = -1;
    int         acc_cnt  = 0;

    always @(negedge clk) begin
        logic [7:0] ref_p;
        logic [8:0] got;
        cyc++;
        if (mon_en) begin
            if (in_valid && in_ready) begin
                ref_p = 8'(a * b);
                exp_q.push_back({ref_p == 8'd0, ref_p});
                acc_cnt++;
                if (b2b_chk && last_acc >= 0)
                    check("b2b_spacing", cyc - last_acc, 6);
                last_acc = cyc;
            end
            check("ready_valid_exclusive", {31'd0, in_ready && out_valid}, 0);
            if (!out_valid)
                check("idle_outputs_zero", {23'd0, zero, product}, 0);
            else
                check("out_has_txn", {31'd0, exp_q.size() != 0}, 1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("sb_product_zero", {23'd0, zero, product}, {23'd0, got});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_in_ready", {31'd0, in_ready}, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_b,
                           input logic [7:0] ep, input logic ez);
        int n;
        wait_idle();
        a = ta; b = tb_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", n, 5);
        check("product", {24'd0, product}, {24'd0, ep});
        check("zero", {31'd0, zero}, {31'd0, ez});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_take_out_valid", {31'd0, out_valid}, 0);
        check("post_take_in_ready", {31'd0, in_ready}, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [7:0] prod;
        logic       z;
    } vec_t;

    vec_t vecs[10];
    bit   rand_ready = 1'b0;

    initial begin
        vecs[0] = '{4'hF, 4'hF, 8'hE1, 1'b0};
        vecs[1] = '{4'h7, 4'h3, 8'h15, 1'b0};
        vecs[2] = '{4'h0, 4'h9, 8'h00, 1'b1};
        vecs[3] = '{4'h5, 4'h0, 8'h00, 1'b1};
        vecs[4] = '{4'hC, 4'h5, 8'h3C, 1'b0};
        vecs[5] = '{4'h2, 4'h3, 8'h06, 1'b0};
        vecs[6] = '{4'hB, 4'hD, 8'h8F, 1'b0};
        vecs[7] = '{4'h8, 4'h2, 8'h10, 1'b0};
        vecs[8] = '{4'hF, 4'h1, 8'h0F, 1'b0};
        vecs[9] = '{4'h1, 4'hF, 8'h0F, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_product", {24'd0, product}, 0);
        check("rst_zero", {31'd0, zero}, 0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].z);

        // backpressure with noisy inputs while waiting
        wait_idle();
        a = 4'hC; b = 4'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            a = 4'($urandom); b = 4'($urandom); in_valid = ~in_valid;
            check("bp_product", {24'd0, product}, 32'h3C);
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", {31'd0, out_valid}, 0);
        check("bp_release_in_ready", {31'd0, in_ready}, 1);

        // asynchronous reset during CALC iteration 2
        wait_idle();
        a = 4'h9; b = 4'h9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_product", {24'd0, product}, 0);
        check("midrst_zero", {31'd0, zero}, 0);
        check("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", {31'd0, in_ready}, 1);
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_no_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;
        run_txn(4'h2, 4'h3, 8'h06, 1'b0);

        // back-to-back: in_valid and out_ready held high
        acc_cnt = 0; last_acc = -1; b2b_chk = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        b2b_chk = 1'b0;
        check("b2b_accepts", {31'd0, acc_cnt >= 9}, 1);
        drain();
        out_ready = 1'b0;

        // exhaustive sweep with random consumer stalls
        rand_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    wait_idle();
                    a = 4'(i >> 4); b = 4'(i);
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                rand_ready = 1'b0;
            end
            begin
                while (rand_ready) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
